// File: rtl/traffic_light_controller.sv
// -----------------------------------------------------------------------------
// traffic_light_controller
//
// Single-approach traffic light. A prescaler derives a one-second tick from
// the board quartz clock. The light sequences GREEN -> YELLOW -> RED -> GREEN.
// GREEN is left only when its minimum time has expired and a car request is
// present, either live on carDetected or latched earlier in the green phase.
//
// Ports:
//   quartzClock  in   system clock, rising-edge active
//   resetN       in   asynchronous active-low reset
//   carDetected  in   vehicle request (level, synchronous to quartzClock)
//   green        out  green lamp  (registered, one-hot with yellow/red)
//   yellow       out  yellow lamp (registered)
//   red          out  red lamp    (registered)
//   timerDisp    out  seconds remaining in the current phase (registered)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module traffic_light_controller #(
  parameter int unsigned CLK_DIV     = 50_000_000,
  parameter int unsigned GREEN_MIN   = 10,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned RED_TIME    = 8
) (
  input  logic       quartzClock,
  input  logic       resetN,
  input  logic       carDetected,
  output logic       green,
  output logic       yellow,
  output logic       red,
  output logic [3:0] timerDisp
);

  localparam int unsigned CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  localparam logic [3:0] GREEN_LOAD  = 4'(GREEN_MIN);
  localparam logic [3:0] YELLOW_LOAD = 4'(YELLOW_TIME);
  localparam logic [3:0] RED_LOAD    = 4'(RED_TIME);

  // 2'b11 is unused and falls back to GREEN.
  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_RED    = 2'd2;

  logic [1:0]    state, nextState;
  logic [CW-1:0] preCount, nextCount;
  logic          reqLatch, nextLatch;
  logic [3:0]    nextTimer;
  logic          greenNxt, yellowNxt, redNxt;
  logic          tick;

  assign tick = (preCount == CNT_MAX);

  // State register: every output is a flop, updated on the same edge as state.
  always_ff @(posedge quartzClock or negedge resetN) begin
    if (!resetN) begin
      state     <= S_GREEN;
      preCount  <= '0;
      reqLatch  <= 1'b0;
      timerDisp <= GREEN_LOAD;
      green     <= 1'b1;
      yellow    <= 1'b0;
      red       <= 1'b0;
    end else begin
      state     <= nextState;
      preCount  <= nextCount;
      reqLatch  <= nextLatch;
      timerDisp <= nextTimer;
      green     <= greenNxt;
      yellow    <= yellowNxt;
      red       <= redNxt;
    end
  end

  // Next-state logic. Every phase entry clears the prescaler so the first
  // displayed second of the new phase is a full CLK_DIV clocks long.
  always_comb begin
    nextState = state;
    nextTimer = timerDisp;
    nextCount = tick ? '0 : preCount + CW'(1);
    nextLatch = reqLatch;
    case (state)
      S_GREEN: begin
        nextLatch = reqLatch | carDetected;
        // The exit test uses the registered timer, so a request that arrives
        // on the tick that reaches 0 is honoured one clock later.
        if ((timerDisp == 4'd0) && (carDetected || reqLatch)) begin
          nextState = S_YELLOW;
          nextTimer = YELLOW_LOAD;
          nextCount = '0;
          nextLatch = 1'b0;
        end else if (tick && (timerDisp != 4'd0)) begin
          nextTimer = timerDisp - 4'd1;
        end
      end
      S_YELLOW: begin
        if (tick) begin
          // <= 1 rather than == 1 so a corrupted 0 cannot stall the phase.
          if (timerDisp <= 4'd1) begin
            nextState = S_RED;
            nextTimer = RED_LOAD;
            nextCount = '0;
          end else begin
            nextTimer = timerDisp - 4'd1;
          end
        end
      end
      S_RED: begin
        if (tick) begin
          if (timerDisp <= 4'd1) begin
            nextState = S_GREEN;
            nextTimer = GREEN_LOAD;
            nextCount = '0;
          end else begin
            nextTimer = timerDisp - 4'd1;
          end
        end
      end
      default: begin
        nextState = S_GREEN;
        nextTimer = GREEN_LOAD;
        nextCount = '0;
        nextLatch = 1'b0;
      end
    endcase
  end

  // Output decode from the next state, so lamps are registered yet change
  // on the transition edge itself.
  always_comb begin
    greenNxt  = 1'b0;
    yellowNxt = 1'b0;
    redNxt    = 1'b0;
    case (nextState)
      S_YELLOW: yellowNxt = 1'b1;
      S_RED:    redNxt    = 1'b1;
      default:  greenNxt  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
`timescale 1ns/1ps
module tb_traffic_light_controller;

  localparam int CLK_DIV     = 4;
  localparam int GREEN_MIN   = 10;
  localparam int YELLOW_TIME = 3;
  localparam int RED_TIME    = 8;

  localparam logic [2:0] LG = 3'b100;
  localparam logic [2:0] LY = 3'b010;
  localparam logic [2:0] LR = 3'b001;

  logic       clk = 1'b0;
  logic       resetN = 1'b1;
  logic       carDetected = 1'b0;
  logic       green, yellow, red;
  logic [3:0] timerDisp;

  int vectors = 0;
  int miscompares = 0;

  always #10 clk = ~clk;

  traffic_light_controller #(
    .CLK_DIV    (CLK_DIV),
    .GREEN_MIN  (GREEN_MIN),
    .YELLOW_TIME(YELLOW_TIME),
    .RED_TIME   (RED_TIME)
  ) main (
    .quartzClock(clk),
    .resetN     (resetN),
    .carDetected(carDetected),
    .green      (green),
    .yellow     (yellow),
    .red        (red),
    .timerDisp  (timerDisp)
  );

  // Reference model: phase plus clocks elapsed since phase entry. The display
  // value is derived arithmetically from elapsed time.
  int mPhase;   // 0 green, 1 yellow, 2 red
  int mEl;
  bit mReq;

  function automatic logic [6:0] modelOut();
    int secs;
    secs = mEl / CLK_DIV;
    case (mPhase)
      0:       return {LG, (secs >= GREEN_MIN) ? 4'd0 : 4'(GREEN_MIN - secs)};
      1:       return {LY, 4'(YELLOW_TIME - secs)};
      default: return {LR, 4'(RED_TIME - secs)};
    endcase
  endfunction

  task automatic modelStep(input bit car);
    logic [6:0] o;
    o = modelOut();
    case (mPhase)
      0: begin
        if (o[3:0] == 4'd0 && (car || mReq)) begin
          mPhase = 1; mEl = 0; mReq = 1'b0;
        end else begin
          mReq = mReq | car; mEl++;
        end
      end
      1: begin
        mEl++;
        if (mEl == YELLOW_TIME * CLK_DIV) begin mPhase = 2; mEl = 0; end
      end
      default: begin
        mEl++;
        if (mEl == RED_TIME * CLK_DIV) begin mPhase = 0; mEl = 0; end
      end
    endcase
  endtask

  task automatic modelReset();
    mPhase = 0; mEl = 0; mReq = 1'b0;
  endtask

  task automatic check(input string name, input logic [6:0] exp);
    vectors++;
    if ({green, yellow, red, timerDisp} !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got g/y/r=%b timer=%0d, expected g/y/r=%b timer=%0d",
               name, $time, {green, yellow, red}, timerDisp, exp[6:4], exp[3:0]);
    end
  endtask

  task automatic checkInv(input string name);
    vectors++;
    if ($countones({green, yellow, red}) != 1 || ((yellow || red) && timerDisp == 4'd0)) begin
      miscompares++;
      $display("FAIL invariant %s @%0t: got g/y/r=%b timer=%0d, expected one-hot lamps and nonzero timer in yellow/red",
               name, $time, {green, yellow, red}, timerDisp);
    end
  endtask

  // Drive one clock: input set away from the edge, outputs sampled 5 ns after it.
  task automatic cycle(input bit car, input string name);
    carDetected = car;
    @(posedge clk);
    modelStep(car);
    #5;
    check(name, modelOut());
    checkInv(name);
  endtask

  task automatic applyReset();
    resetN = 1'b0;
    modelReset();
    #1;
    check("async reset", {LG, 4'(GREEN_MIN)});
    repeat (3) begin
      @(posedge clk);
      #5;
      check("reset hold", {LG, 4'(GREEN_MIN)});
      checkInv("reset hold");
    end
    resetN = 1'b1;
  endtask

  typedef struct {
    bit         rst;
    bit         car;
    int         n;
    logic [2:0] lamps;
    logic [3:0] t;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    // Idle: countdown to 0 and hold in green.
    tbl.push_back('{1'b1, 1'b0, 4,   LG, 4'd9});
    tbl.push_back('{1'b0, 1'b0, 36,  LG, 4'd0});
    tbl.push_back('{1'b0, 1'b0, 160, LG, 4'd0});
    // Continuous request: full cycle and repeat.
    tbl.push_back('{1'b1, 1'b1, 40,  LG, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 1,   LY, 4'd3});
    tbl.push_back('{1'b0, 1'b1, 4,   LY, 4'd2});
    tbl.push_back('{1'b0, 1'b1, 4,   LY, 4'd1});
    tbl.push_back('{1'b0, 1'b1, 3,   LY, 4'd1});
    tbl.push_back('{1'b0, 1'b1, 1,   LR, 4'd8});
    tbl.push_back('{1'b0, 1'b1, 31,  LR, 4'd1});
    tbl.push_back('{1'b0, 1'b1, 1,   LG, 4'd10});
    tbl.push_back('{1'b0, 1'b1, 40,  LG, 4'd0});
    tbl.push_back('{1'b0, 1'b1, 1,   LY, 4'd3});
    // Single-cycle pulse at clock 8 is latched.
    tbl.push_back('{1'b1, 1'b0, 7,   LG, 4'd9});
    tbl.push_back('{1'b0, 1'b1, 1,   LG, 4'd8});
    tbl.push_back('{1'b0, 1'b0, 32,  LG, 4'd0});
    tbl.push_back('{1'b0, 1'b0, 1,   LY, 4'd3});
    tbl.push_back('{1'b0, 1'b0, 12,  LR, 4'd8});
    tbl.push_back('{1'b0, 1'b0, 32,  LG, 4'd10});
    tbl.push_back('{1'b0, 1'b0, 100, LG, 4'd0});
    // Requests during yellow/red are ignored.
    tbl.push_back('{1'b1, 1'b1, 41,  LY, 4'd3});
    tbl.push_back('{1'b0, 1'b1, 12,  LR, 4'd8});
    tbl.push_back('{1'b0, 1'b1, 32,  LG, 4'd10});
    tbl.push_back('{1'b0, 1'b0, 100, LG, 4'd0});

    #3;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) applyReset();
      repeat (tbl[i].n) cycle(tbl[i].car, "model");
      check($sformatf("table[%0d]", i), {tbl[i].lamps, tbl[i].t});
    end

    // Asynchronous reset mid-clock during red with timer 5.
    applyReset();
    repeat (41) cycle(1'b1, "to yellow");
    repeat (24) cycle(1'b0, "to red 5");
    check("red at 5", {LR, 4'd5});
    #3;
    resetN = 1'b0;
    modelReset();
    #1;
    check("async reset mid-red", {LG, 4'(GREEN_MIN)});
    checkInv("async reset mid-red");
    @(posedge clk);
    #5;
    check("reset held after red", {LG, 4'(GREEN_MIN)});
    resetN = 1'b1;
    repeat (4) cycle(1'b0, "after reset");
    check("prescaler cleared by reset", {LG, 4'd9});

    // Randomized traffic with occasional resets.
    applyReset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) applyReset();
      else cycle($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 3 : 30), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
